// File: rtl/booth_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : booth_mult_seq_ctrl
// Brief    : Sequential radix-4 Booth multiplier controller for RV32M MUL/MULH*.
// Revision : 1.0
// ============================================================================
module booth_mult_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int NDIG = (XLEN + 2) / 2;
  localparam int EXTW = XLEN + 2;
  localparam int ACCW = 2 * XLEN + 4;
  localparam int CNTW = $clog2(NDIG + 1);
  localparam logic [CNTW-1:0] C_LAST = CNTW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [ACCW-1:0]    acc_q, acc_d;
  logic [ACCW-1:0]    mcand_q, mcand_d;
  logic [EXTW:0]      mplr_q, mplr_d;
  logic               hi_q, hi_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [XLEN-1:0]    res_q, res_d;
  logic [TAG_W-1:0]   otag_q, otag_d;

  logic               w_a_sgn;
  logic               w_b_sgn;
  logic [ACCW-1:0]    w_a_ext;
  logic [EXTW:0]      w_b_ext;
  logic [ACCW-1:0]    w_pp;
  logic [ACCW-1:0]    w_acc_sum;

  assign w_a_sgn = (in_op == 2'b01) || (in_op == 2'b10);
  assign w_b_sgn = (in_op == 2'b01);
  // Multiplicand is pre-extended to the full accumulator width and shifted
  // left by two each digit, so the partial product is already weighted by 4^j.
  assign w_a_ext = {{(ACCW - XLEN){w_a_sgn & in_a[XLEN-1]}}, in_a};
  // Multiplier carries the implicit Bx[-1]=0 in bit 0; shifting right by two
  // exposes the next Booth triplet in bits [2:0].
  assign w_b_ext = {{2{w_b_sgn & in_b[XLEN-1]}}, in_b, 1'b0};

  always_comb begin
    w_pp = '0;
    case (mplr_q[2:0])
      3'b001, 3'b010: w_pp = mcand_q;
      3'b011:         w_pp = mcand_q << 1;
      3'b100:         w_pp = -(mcand_q << 1);
      3'b101, 3'b110: w_pp = -mcand_q;
      default:        w_pp = '0;
    endcase
  end

  assign w_acc_sum = acc_q + w_pp;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    hi_d    = hi_q;
    tag_d   = tag_q;
    res_d   = res_q;
    otag_d  = otag_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          acc_d   = '0;
          mcand_d = w_a_ext;
          mplr_d  = w_b_ext;
          hi_d    = (in_op != 2'b00);
          tag_d   = in_tag;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = w_acc_sum;
          mcand_d = mcand_q << 2;
          mplr_d  = mplr_q >> 2;
          cnt_d   = cnt_q + CNTW'(1);
          if (cnt_q == C_LAST) begin
            state_d = S_DONE;
            res_d   = hi_q ? w_acc_sum[2*XLEN-1:XLEN] : w_acc_sum[XLEN-1:0];
            otag_d  = tag_q;
          end
        end
      end
      S_DONE: begin
        if (flush || out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      hi_q    <= 1'b0;
      tag_q   <= '0;
      res_q   <= '0;
      otag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      hi_q    <= hi_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      otag_q  <= otag_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_result = res_q;
  assign out_tag    = otag_q;

endmodule
`default_nettype wire
